// File: rtl/s_axi_write.sv
// AXI4-Lite write-channel slave (AW/W/B) driving the register-file write port.
// Optional macro S_AXI_WSTRB_EN: pass wstrb through as byte enables (else full-word writes).
module s_axi_write #(
  parameter int IDX_W = 7
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             awvalid,
  output logic             awready,
  input  logic [31:0]      awaddr,
  input  logic             wvalid,
  output logic             wready,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic             bvalid,
  input  logic             bready,
  output logic [1:0]       bresp,
  output logic             reg_we,
  output logic [IDX_W-1:0] reg_idx,
  output logic [31:0]      reg_wdata,
  output logic [3:0]       reg_be
);

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_AW, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic             oor_q;
  logic [31:0]      data_q;

  logic             aw_hs, w_hs, done;
  logic [IDX_W-1:0] idx_n;
  logic             oor_n;
  logic [31:0]      data_n;
  logic [3:0]       be_n;
  logic             unused_in;

  // Ready is a pure state decode so valid never feeds back into ready.
  assign awready = (state == IDLE) || (state == WAIT_AW);
  assign wready  = (state == IDLE) || (state == WAIT_W);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // The completing handshake bypasses its holding register so the write issues on that edge.
  assign idx_n  = aw_hs ? awaddr[IDX_W+1:2] : idx_q;
  assign oor_n  = aw_hs ? (awaddr[31:IDX_W+2] != '0) : oor_q;
  assign data_n = w_hs ? wdata : data_q;
  assign done   = ((state == IDLE) && aw_hs && w_hs) ||
                  ((state == WAIT_W) && w_hs) ||
                  ((state == WAIT_AW) && aw_hs);

`ifdef S_AXI_WSTRB_EN
  logic [3:0] strb_q;
  assign be_n      = w_hs ? wstrb : strb_q;
  assign unused_in = ^awaddr[1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  strb_q <= '0;
    else if (w_hs) strb_q <= wstrb;
  end
`else
  assign be_n      = 4'hF;
  assign unused_in = ^{awaddr[1:0], wstrb};
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      data_q    <= '0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      reg_we    <= 1'b0;
      reg_idx   <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
    end else begin
      reg_we <= 1'b0;
      if (aw_hs) begin
        idx_q <= awaddr[IDX_W+1:2];
        oor_q <= (awaddr[31:IDX_W+2] != '0);
      end
      if (w_hs) data_q <= wdata;

      case (state)
        IDLE: begin
          if (aw_hs && w_hs) state <= RESP;
          else if (aw_hs)    state <= WAIT_W;
          else if (w_hs)     state <= WAIT_AW;
        end
        WAIT_W:  if (w_hs)  state <= RESP;
        WAIT_AW: if (aw_hs) state <= RESP;
        RESP: begin
          if (bready) begin
            state  <= IDLE;
            bvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (done) begin
        reg_we    <= !oor_n;
        reg_idx   <= idx_n;
        reg_wdata <= data_n;
        reg_be    <= be_n;
        bresp     <= oor_n ? 2'b10 : 2'b00;
        bvalid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s_axi_write.sv
// Directed bench for s_axi_write: handshake orderings, range check, B backpressure, strobes, reset.
module tb_s_axi_write;
  localparam int IDX_W = 7;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             awvalid, awready, wvalid, wready, bvalid, bready, reg_we;
  logic [31:0]      awaddr, wdata, reg_wdata;
  logic [3:0]       wstrb, reg_be;
  logic [1:0]       bresp;
  logic [IDX_W-1:0] reg_idx;

  int          n_chk = 0;
  int          n_err = 0;
  int          we_cnt = 0;
  int          we0;
  logic [31:0] mem [128];

`ifdef S_AXI_WSTRB_EN
  localparam logic [3:0]  EXP_BE5  = 4'h5;
  localparam logic [31:0] EXP_MEM0 = 32'h00BB00DD;
`else
  localparam logic [3:0]  EXP_BE5  = 4'hF;
  localparam logic [31:0] EXP_MEM0 = 32'hAABBCCDD;
`endif

  always #5 aclk = ~aclk;

  s_axi_write #(.IDX_W(IDX_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_wdata(reg_wdata), .reg_be(reg_be)
  );

  // Shadow register file standing in for the read slave's view.
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(negedge aclk) begin
    if (reg_we) begin
      we_cnt <= we_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (reg_be[b]) mem[reg_idx][8*b +: 8] <= reg_wdata[8*b +: 8];
    end
  end

  task automatic test_reset();
    aresetn = 1'b0; awvalid = 0; wvalid = 0; bready = 1;
    awaddr = '0; wdata = '0; wstrb = '0;
    repeat (2) @(posedge aclk);
    #1;
    n_chk++; if (awready !== 1'b1) begin n_err++; $display("FAIL rst_awready: got %b want 1", awready); end
    n_chk++; if (wready !== 1'b1) begin n_err++; $display("FAIL rst_wready: got %b want 1", wready); end
    n_chk++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL rst_bvalid: got %b want 0", bvalid); end
    n_chk++; if (bresp !== 2'b00) begin n_err++; $display("FAIL rst_bresp: got %b want 00", bresp); end
    n_chk++; if ({reg_we, reg_idx, reg_wdata, reg_be} !== '0) begin n_err++;
      $display("FAIL rst_regport: got we=%b idx=%h d=%h be=%h want 0", reg_we, reg_idx, reg_wdata, reg_be); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_simultaneous();
    we0 = we_cnt;
    awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    n_chk++; if (reg_we !== 1'b1) begin n_err++; $display("FAIL sim_we: got %b want 1", reg_we); end
    n_chk++; if (reg_idx !== 7'd4) begin n_err++; $display("FAIL sim_idx: got %0d want 4", reg_idx); end
    n_chk++; if (reg_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sim_wdata: got %h want deadbeef", reg_wdata); end
    n_chk++; if (reg_be !== 4'hF) begin n_err++; $display("FAIL sim_be: got %h want f", reg_be); end
    n_chk++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_err++; $display("FAIL sim_b: got v=%b r=%b want v=1 r=00", bvalid, bresp); end
    n_chk++; if (awready !== 1'b0 || wready !== 1'b0) begin n_err++; $display("FAIL sim_resp_rdy: got %b%b want 00", awready, wready); end
    @(posedge aclk); #1;
    n_chk++; if (reg_we !== 1'b0 || bvalid !== 1'b0) begin n_err++; $display("FAIL sim_done: got we=%b bv=%b want 0 0", reg_we, bvalid); end
    n_chk++; if (awready !== 1'b1 || wready !== 1'b1) begin n_err++; $display("FAIL sim_idle_rdy: got %b%b want 11", awready, wready); end
    n_chk++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sim_readback: got %h want deadbeef", mem[4]); end
    n_chk++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL sim_wecnt: got %0d want 1", we_cnt - we0); end
  endtask

  task automatic test_split_order();
    we0 = we_cnt;
    awvalid = 1; awaddr = 32'h1FC;
    @(posedge aclk); #1;
    awvalid = 0;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin n_err++;
        $display("FAIL waitw_rdy: got aw=%b w=%b bv=%b want 0 1 0", awready, wready, bvalid); end
      if (c < 2) begin @(posedge aclk); #1; end
    end
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
    @(posedge aclk); #1;
    wvalid = 0;
    n_chk++; if (reg_we !== 1'b1 || reg_idx !== 7'd127) begin n_err++; $display("FAIL awfirst_idx: got we=%b idx=%0d want 1 127", reg_we, reg_idx); end
    n_chk++; if (reg_wdata !== 32'h12345678) begin n_err++; $display("FAIL awfirst_wdata: got %h want 12345678", reg_wdata); end
    @(posedge aclk); #1;
    wvalid = 1; wdata = 32'hCAFEF00D;
    @(posedge aclk); #1;
    wvalid = 0;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin n_err++;
        $display("FAIL waitaw_rdy: got aw=%b w=%b bv=%b want 1 0 0", awready, wready, bvalid); end
      if (c < 2) begin @(posedge aclk); #1; end
    end
    awvalid = 1; awaddr = 32'h004;
    @(posedge aclk); #1;
    awvalid = 0;
    n_chk++; if (reg_we !== 1'b1 || reg_idx !== 7'd1) begin n_err++; $display("FAIL wfirst_idx: got we=%b idx=%0d want 1 1", reg_we, reg_idx); end
    n_chk++; if (reg_wdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL wfirst_wdata: got %h want cafef00d", reg_wdata); end
    @(posedge aclk); #1;
    n_chk++; if (we_cnt - we0 !== 2) begin n_err++; $display("FAIL split_wecnt: got %0d want 2", we_cnt - we0); end
    n_chk++; if (mem[127] !== 32'h12345678 || mem[1] !== 32'hCAFEF00D) begin n_err++;
      $display("FAIL split_readback: got %h %h want 12345678 cafef00d", mem[127], mem[1]); end
  endtask

  task automatic test_out_of_range();
    we0 = we_cnt;
    bready = 0;
    awvalid = 1; awaddr = 32'h200; wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    for (int c = 0; c < 2; c++) begin
      n_chk++; if (bvalid !== 1'b1 || bresp !== 2'b10 || reg_we !== 1'b0) begin n_err++;
        $display("FAIL oor_resp: got bv=%b r=%b we=%b want 1 10 0", bvalid, bresp, reg_we); end
      @(posedge aclk); #1;
    end
    bready = 1;
    @(posedge aclk); #1;
    n_chk++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL oor_done: got bv=%b want 0", bvalid); end
    n_chk++; if (we_cnt !== we0 || mem[0] !== 32'h0) begin n_err++;
      $display("FAIL oor_nowrite: got cnt=%0d mem0=%h want %0d 0", we_cnt, mem[0], we0); end
  endtask

  task automatic test_b_stall();
    we0 = we_cnt;
    bready = 0;
    awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
    @(posedge aclk); #1;
    n_chk++; if (reg_we !== 1'b1 || reg_idx !== 7'd2) begin n_err++; $display("FAIL stall_we: got we=%b idx=%0d want 1 2", reg_we, reg_idx); end
    awaddr = 32'h30; wdata = 32'h99;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      n_chk++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0 || reg_we !== 1'b0) begin n_err++;
        $display("FAIL stall_hold%0d: got bv=%b r=%b aw=%b w=%b we=%b want 1 00 0 0 0", c, bvalid, bresp, awready, wready, reg_we); end
    end
    awvalid = 0; wvalid = 0; bready = 1;
    @(posedge aclk); #1;
    n_chk++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin n_err++;
      $display("FAIL stall_release: got bv=%b aw=%b w=%b want 0 1 1", bvalid, awready, wready); end
    n_chk++; if (we_cnt - we0 !== 1 || mem[2] !== 32'h55 || mem[12] !== 32'h0) begin n_err++;
      $display("FAIL stall_writes: got cnt=%0d m2=%h m12=%h want 1 55 0", we_cnt - we0, mem[2], mem[12]); end
  endtask

  task automatic test_wstrb();
    awvalid = 1; awaddr = 32'h0; wvalid = 1; wdata = 32'hAABBCCDD; wstrb = 4'b0101;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    n_chk++; if (reg_we !== 1'b1 || reg_be !== EXP_BE5) begin n_err++; $display("FAIL strb_be: got we=%b be=%h want 1 %h", reg_we, reg_be, EXP_BE5); end
    @(posedge aclk); #1;
    n_chk++; if (mem[0] !== EXP_MEM0) begin n_err++; $display("FAIL strb_readback: got %h want %h", mem[0], EXP_MEM0); end
  endtask

  task automatic test_reset_mid();
    we0 = we_cnt;
    awvalid = 1; awaddr = 32'hC;
    @(posedge aclk); #1;
    awvalid = 0;
    n_chk++; if (awready !== 1'b0) begin n_err++; $display("FAIL midrst_waitw: got aw=%b want 0", awready); end
    #2 aresetn = 1'b0;
    #2;
    n_chk++; if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0 || bresp !== 2'b00) begin n_err++;
      $display("FAIL midrst_ctl: got aw=%b w=%b bv=%b r=%b want 1 1 0 00", awready, wready, bvalid, bresp); end
    n_chk++; if ({reg_we, reg_idx, reg_wdata, reg_be} !== '0) begin n_err++;
      $display("FAIL midrst_regport: got we=%b idx=%h d=%h be=%h want 0", reg_we, reg_idx, reg_wdata, reg_be); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    n_chk++; if (we_cnt !== we0) begin n_err++; $display("FAIL midrst_nowe: got %0d want %0d", we_cnt, we0); end
    awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 32'h0C0C0C0C; wstrb = 4'hF;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    n_chk++; if (reg_we !== 1'b1 || reg_idx !== 7'd3 || bvalid !== 1'b1 || bresp !== 2'b00) begin n_err++;
      $display("FAIL midrst_after: got we=%b idx=%0d bv=%b r=%b want 1 3 1 00", reg_we, reg_idx, bvalid, bresp); end
    @(posedge aclk); #1;
    n_chk++; if (mem[3] !== 32'h0C0C0C0C) begin n_err++; $display("FAIL midrst_readback: got %h want 0c0c0c0c", mem[3]); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_split_order();
    test_out_of_range();
    test_b_stall();
    test_wstrb();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
